// File: rtl/plush_pkg.sv
// Shared constants, instruction field layout and state encoding for the PlushUnit sequencer.
package plush_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned REG_AW  = 5;

    // Instruction field bit positions (LSB of each field)
    localparam int unsigned OP_LSB      = 0;
    localparam int unsigned A_MODE_LSB  = 3;
    localparam int unsigned A_FIELD_LSB = 5;
    localparam int unsigned B_MODE_LSB  = 13;
    localparam int unsigned B_FIELD_LSB = 15;
    localparam int unsigned INSTR_USED  = B_FIELD_LSB + FIELD_W;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_MOV = 3'b011;
    localparam logic [OP_W-1:0] OP_JMP = 3'b100;

    localparam logic [MODE_W-1:0] MODE_M   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_BAD = 2'b01;
    localparam logic [MODE_W-1:0] MODE_N   = 2'b10;
    localparam logic [MODE_W-1:0] MODE_R   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_REQ,
        S_F_CAP,
        S_DECODE,
        S_B_REQ,
        S_B_CAP,
        S_A_REQ,
        S_A_CAP,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/plush_sequencer_if.sv
// Datapath bus between the sequencer (master) and the RAM, regfile and ALU (slave side).
interface plush_sequencer_if
    import plush_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8
);
    logic [PC_W-1:0]   ram_addr;
    logic              ram_write;
    logic [DATA_W-1:0] ram_out;
    logic [DATA_W-1:0] ram_in;
    logic [REG_AW-1:0] regf_addr;
    logic              regf_write;
    logic [DATA_W-1:0] regf_out;
    logic [DATA_W-1:0] regf_in;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_res;

    modport master (
        output ram_addr, ram_write, ram_out,
        output regf_addr, regf_write, regf_out,
        output alu_a, alu_b, alu_op,
        input  ram_in, regf_in, alu_res
    );

    modport slave (
        input  ram_addr, ram_write, ram_out,
        input  regf_addr, regf_write, regf_out,
        input  alu_a, alu_b, alu_op,
        output ram_in, regf_in, alu_res
    );
endinterface

// File: rtl/plush_decode.sv
// Combinational instruction decoder: splits fields and flags bad encodings.
module plush_decode
    import plush_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]  instr,
    output logic [OP_W-1:0]    op,
    output logic [MODE_W-1:0]  a_mode,
    output logic [FIELD_W-1:0] a_field,
    output logic [MODE_W-1:0]  b_mode,
    output logic [FIELD_W-1:0] b_field,
    output logic               legal
);
    logic unused_hi;

    assign op        = instr[OP_LSB +: OP_W];
    assign a_mode    = instr[A_MODE_LSB +: MODE_W];
    assign a_field   = instr[A_FIELD_LSB +: FIELD_W];
    assign b_mode    = instr[B_MODE_LSB +: MODE_W];
    assign b_field   = instr[B_FIELD_LSB +: FIELD_W];
    assign unused_hi = ^instr[DATA_W-1:INSTR_USED];

    // Only operands the opcode actually uses are checked; A must be writable for ADD/SUB/MOV.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_NOP:                 legal = 1'b1;
            OP_ADD, OP_SUB, OP_MOV: legal = (a_mode == MODE_M || a_mode == MODE_R) &&
                                            (b_mode != MODE_BAD);
            OP_JMP:                 legal = (a_mode != MODE_BAD);
            default:                legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/plush_sequencer.sv
// Multi-cycle fetch/decode/operand/execute/writeback controller for the PlushUnit core.
module plush_sequencer
    import plush_pkg::*;
#(
    parameter int unsigned    DATA_W   = 32,
    parameter int unsigned    PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [PC_W-1:0]  pc,
    plush_sequencer_if.master bus
);
    state_t state, next_state;

    logic [DATA_W-1:0]  instr, a_val, b_val;
    logic [OP_W-1:0]    op;
    logic [MODE_W-1:0]  a_mode, b_mode, cap_mode;
    logic [FIELD_W-1:0] a_field, b_field, cap_field;
    logic               legal;
    state_t             done_state_c;
    logic [DATA_W-1:0]  cap_val_c, result_c;

    logic              busy_d, halted_d, illegal_d;
    logic [PC_W-1:0]   pc_d, ram_addr_d;
    logic [DATA_W-1:0] instr_d, a_val_d, b_val_d, ram_out_d, regf_out_d, alu_a_d, alu_b_d;
    logic [REG_AW-1:0] regf_addr_d;
    logic              ram_write_d, regf_write_d;
    logic [OP_W-1:0]   alu_op_d;

    plush_decode #(.DATA_W(DATA_W)) u_decode (
        .instr   (instr),
        .op      (op),
        .a_mode  (a_mode),
        .a_field (a_field),
        .b_mode  (b_mode),
        .b_field (b_field),
        .legal   (legal)
    );

    // Operand being captured this cycle and the value that mode delivers.
    assign cap_mode     = (state == S_A_CAP) ? a_mode : b_mode;
    assign cap_field    = (state == S_A_CAP) ? a_field : b_field;
    assign done_state_c = run ? S_F_REQ : S_IDLE;
    assign result_c     = (op == OP_MOV) ? b_val : bus.alu_res;

    always_comb begin
        case (cap_mode)
            MODE_R:  cap_val_c = bus.regf_in;
            MODE_N:  cap_val_c = DATA_W'(cap_field);
            default: cap_val_c = bus.ram_in;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            busy           <= 1'b0;
            halted         <= 1'b0;
            illegal        <= 1'b0;
            instr          <= '0;
            a_val          <= '0;
            b_val          <= '0;
            bus.ram_addr   <= '0;
            bus.ram_write  <= 1'b0;
            bus.ram_out    <= '0;
            bus.regf_addr  <= '0;
            bus.regf_write <= 1'b0;
            bus.regf_out   <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= OP_NOP;
        end else begin
            state          <= next_state;
            pc             <= pc_d;
            busy           <= busy_d;
            halted         <= halted_d;
            illegal        <= illegal_d;
            instr          <= instr_d;
            a_val          <= a_val_d;
            b_val          <= b_val_d;
            bus.ram_addr   <= ram_addr_d;
            bus.ram_write  <= ram_write_d;
            bus.ram_out    <= ram_out_d;
            bus.regf_addr  <= regf_addr_d;
            bus.regf_write <= regf_write_d;
            bus.regf_out   <= regf_out_d;
            bus.alu_a      <= alu_a_d;
            bus.alu_b      <= alu_b_d;
            bus.alu_op     <= alu_op_d;
        end
    end

    // Next state, then the output values that the entered state must present.
    always_comb begin
        next_state   = state;
        pc_d         = pc;
        illegal_d    = illegal;
        instr_d      = instr;
        a_val_d      = a_val;
        b_val_d      = b_val;
        ram_addr_d   = bus.ram_addr;
        ram_out_d    = bus.ram_out;
        regf_addr_d  = bus.regf_addr;
        regf_out_d   = bus.regf_out;
        alu_a_d      = bus.alu_a;
        alu_b_d      = bus.alu_b;
        ram_write_d  = 1'b0;
        regf_write_d = 1'b0;
        alu_op_d     = OP_NOP;

        case (state)
            S_IDLE:   if (run) next_state = S_F_REQ;
            S_F_REQ:  next_state = S_F_CAP;
            S_F_CAP: begin
                instr_d    = bus.ram_in;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal_d  = 1'b1;
                    next_state = S_HALT;
                end else if (op == OP_NOP) begin
                    pc_d       = pc + PC_W'(1);
                    next_state = done_state_c;
                end else if (op == OP_JMP) begin
                    next_state = S_A_REQ;
                end else begin
                    next_state = S_B_REQ;
                end
            end
            S_B_REQ:  next_state = S_B_CAP;
            S_B_CAP: begin
                b_val_d    = cap_val_c;
                next_state = (op == OP_MOV) ? S_EXEC : S_A_REQ;
            end
            S_A_REQ:  next_state = S_A_CAP;
            S_A_CAP: begin
                a_val_d    = cap_val_c;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (op == OP_JMP) begin
                    pc_d       = a_val[PC_W-1:0];
                    next_state = done_state_c;
                end else begin
                    next_state = S_WB;
                end
            end
            S_WB: begin
                pc_d       = pc + PC_W'(1);
                next_state = done_state_c;
            end
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase

        busy_d   = (next_state != S_IDLE) && (next_state != S_HALT);
        halted_d = (next_state == S_HALT);

        case (next_state)
            S_F_REQ: ram_addr_d = pc_d;
            S_B_REQ: begin
                if (b_mode == MODE_M)      ram_addr_d  = PC_W'(b_field);
                else if (b_mode == MODE_R) regf_addr_d = b_field[REG_AW-1:0];
            end
            S_A_REQ: begin
                if (a_mode == MODE_M)      ram_addr_d  = PC_W'(a_field);
                else if (a_mode == MODE_R) regf_addr_d = a_field[REG_AW-1:0];
            end
            S_EXEC: begin
                alu_a_d = a_val_d;
                alu_b_d = b_val_d;
                if (op == OP_ADD || op == OP_SUB) alu_op_d = op;
            end
            S_WB: begin
                if (a_mode == MODE_R) begin
                    regf_write_d = 1'b1;
                    regf_addr_d  = a_field[REG_AW-1:0];
                    regf_out_d   = result_c;
                end else begin
                    ram_write_d  = 1'b1;
                    ram_addr_d   = PC_W'(a_field);
                    ram_out_d    = result_c;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/plush_sequencer.md
Name: plush_sequencer

Overview:
- Multi-cycle control FSM for the PlushUnit core.
- Fetches 32-bit instructions from the 256-word RAM and decodes them.
- Gathers operands from regfile, RAM or immediate; drives the ALU; writes back.
- Owns the PC; sole master of the ALU, regfile and RAM ports.

Parameters:
- DATA_W, 32, datapath/instruction width.
- PC_W, 8, PC and RAM address width.
- RESET_PC, 8'h00, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute, 0 = stop at next instruction boundary.
- busy  out  1  high while not in IDLE or HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when HALT is entered due to a bad encoding.
- pc  out  PC_W  current instruction address.
- ram_addr  out  PC_W  RAM address.
- ram_write  out  1  one-cycle write strobe.
- ram_out  out  DATA_W  RAM write data.
- ram_in  in  DATA_W  RAM read data; valid the cycle after ram_addr is presented.
- regf_addr  out  5  regfile address.
- regf_write  out  1  one-cycle write strobe.
- regf_out  out  DATA_W  regfile write data.
- regf_in  in  DATA_W  regfile read data; combinational from regf_addr.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_op  out  3  ALU opcode.
- alu_res  in  DATA_W  ALU result; combinational.

Behaviour:
- Instruction fields:
  - op = [2:0]: NOP 000, ADD 001, SUB 010, MOV 011, JMP 100; 101–111 are illegal.
  - A operand: mode [4:3], field [12:5]. B operand: mode [14:13], field [22:15].
  - Modes: r 11 = regfile[field[4:0]]; m 00 = ram[field]; n 10 = zero-extended immediate field.
  - Mode 01 is illegal.
- Semantics:
  - ADD/SUB: A ← A op B.
  - MOV: A ← B.
  - JMP: pc ← A value[7:0].
  - NOP: no effect.
  - An A operand in mode n is illegal for ADD/SUB/MOV; it is legal for JMP.
- States: IDLE, F_REQ, F_CAP, DECODE, B_REQ, B_CAP, A_REQ, A_CAP, EXEC, WB, HALT.
- Each operand read takes exactly two cycles (REQ drives the address, CAP samples the data), for every mode.
- Fixed latencies from F_REQ to the next F_REQ:
  - NOP: 3 cycles.
  - MOV: 7 cycles (F, F, D, B_REQ, B_CAP, EXEC, WB).
  - ADD/SUB: 9 cycles.
  - JMP: 6 cycles (F, F, D, A_REQ, A_CAP, EXEC).
- Transitions:
  - IDLE→F_REQ when run=1.
  - DECODE→HALT on an illegal encoding, with illegal set.
  - The last state of each instruction goes to F_REQ if run=1, else IDLE.
- EXEC:
  - alu_op=ADD/SUB, alu_a=A value, alu_b=B value; alu_res is captured into the result register.
  - MOV bypasses the ALU (result = B).
  - JMP loads pc in EXEC.
- alu_op=NOP in every state except EXEC.
- WB: exactly one of ram_write/regf_write pulses for one cycle, with address = A field and data = result.
- pc increments by 1 in WB (NOP: in DECODE); 8'hFF wraps to 8'h00.
- The write strobes are never high outside WB.
- run falling mid-instruction: the instruction completes, then the FSM goes to IDLE.
- HALT is left only via reset.
- Reset (including mid-instruction, asynchronous):
  - State = IDLE, pc = RESET_PC, illegal = 0.
  - All other outputs = 0; no write strobe.
- A read and a write of the same RAM word within one instruction (e.g. ADD m,m) are legal: the read completes in CAP before WB.

Decomposition:
- plush_pkg holds:
  - opcode constants NOP/ADD/SUB/MOV/JMP;
  - mode constants r/m/n;
  - the state encoding;
  - field bit positions.
- One sub-module, plush_decode: combinational; instr → op, modes, fields, legal flag.

Test Plan:
- RAM[0]=ADD r1,n5; r1=10; run=1 → regf_write pulse at cycle 9 with regf_addr=1, regf_out=15; pc=1.
- RAM[0]=MOV m8'h40,r3; r3=0xDEAD → ram_write pulse, ram_addr=0x40, ram_out=0xDEAD, 7 cycles; pc=1.
- RAM[0]=SUB m0x10,n1; ram[0x10]=0 → ram_out=0xFFFFFFFF (wrap), ram_addr=0x10.
- RAM[0]=JMP n0x80, then NOP at 0x80; pc=0xFF holding NOP → pc goes 0x80; separately 0xFF→0x00 wrap.
- Opcode 101 → halted=1, illegal=1, busy=0, no strobes; run toggling has no effect; rst_n low clears both flags.
- rst_n asserted during EXEC of ADD → no write strobe, pc=0, state IDLE; after release and run=1, fetch restarts at 0.
